// File: rtl/bram_rd_arbiter_pkg.sv
// bram_arb_pkg: shared constants and helpers for the BRAM read arbiter.
//   READ_LATENCY : cycles from a read grant to its resp_valid strobe. This is
//                  also the depth of the tag pipeline.
//   clog2()      : width of a requester id. The result is never below 1, so
//                  an id always has at least one bit.
package bram_arb_pkg;

  localparam int READ_LATENCY = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bram_rd_arbiter_if.sv
// bram_rd_if: read-request and response bundle between the requesters and
// the arbiter.
//   req_valid  [NUM_REQ]             requester -> arbiter, read request
//   req_addr   [NUM_REQ][ADDR_WIDTH] requester -> arbiter, read address
//   req_ready  [NUM_REQ]             arbiter -> requester, grant (one-hot/zero)
//   resp_valid [NUM_REQ]             arbiter -> requester, data strobe (one-hot/zero)
//   resp_data  [DATA_WIDTH]          arbiter -> requester, shared read data
//
// Handshake: a read transfers in every cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational and is never high
// without req_valid. A requester keeps req_valid and req_addr stable until it
// sees the transfer. Responses have no backpressure: the requester must take
// resp_data in the single cycle in which its resp_valid bit is high.
interface bram_rd_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]              resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bram_rd_arbiter_bram.sv
// bram: simple dual-port block RAM with a 2-cycle registered read path.
// The memory array is read into q1, and q1 is then registered into rd_data.
// A read at the same address as a same-cycle write returns the old contents.
// Nothing in this block is reset.
//   clk      in   clock
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  read data, two cycles after rd_addr is sampled
module bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    q1      <= mem[rd_addr];
    rd_data <= q1;
  end
endmodule

// File: rtl/bram_rd_arbiter.sv
// bram_rd_arbiter: round-robin arbiter that shares the read port of a 2-cycle
// block RAM among NUM_REQ requesters. The write port passes straight through.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   RAM write enable (not arbitrated)
//   wr_addr    in   write address
//   wr_data    in   write data
//   bus        slave modport of bram_rd_if (request, grant, response)
//   idle       out  high when no read is in flight
//   ptr        out  round-robin priority pointer (debug view)
module bram_rd_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  bram_rd_if.slave                    bus,
  output logic                        idle,
  output logic [clog2(NUM_REQ)-1:0]   ptr
);
  localparam int ID_W = clog2(NUM_REQ);

  logic                  gnt_any;
  logic [ID_W-1:0]       gnt_id;
  logic [NUM_REQ-1:0]    gnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ID_W-1:0]       next_ptr;

  logic [READ_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]         tag_id [READ_LATENCY];

  // Scan requesters in order from ptr upward, wrapping past the top index.
  // The first valid requester found wins. No grant is issued during reset.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
    if (!rst_n) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign bus.req_ready = gnt;
  assign rd_addr       = gnt_any ? bus.req_addr[gnt_id] : '0;
  assign next_ptr      = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      tag_v <= '0;
    end else begin
      if (gnt_any) ptr <= next_ptr;
      tag_v <= {tag_v[READ_LATENCY-2:0], gnt_any};
    end
  end

  // The ids carry no meaning while their valid bit is low, so they are not reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int s = 1; s < READ_LATENCY; s++) tag_id[s] <= tag_id[s-1];
  end

  always_comb begin
    bus.resp_valid = '0;
    if (tag_v[READ_LATENCY-1]) bus.resp_valid[tag_id[READ_LATENCY-1]] = 1'b1;
  end

  assign idle = ~|tag_v;

  bram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (bus.resp_data)
  );
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter. One instance has two requesters and
// exercises data, ordering, collision and reset behaviour. A second instance
// has three requesters and checks the wrap-around grant order.
module tb_bram_rd_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // two-requester instance
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          idle2;
  logic [0:0]    ptr2;
  bram_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(2)) bus2 ();

  bram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .bus     (bus2.slave),
    .idle    (idle2),
    .ptr     (ptr2)
  );

  // three-requester instance
  logic          idle3;
  logic [1:0]    ptr3;
  logic          wr_en3 = 1'b0;
  logic [AW-1:0] wr_addr3 = '0;
  logic [DW-1:0] wr_data3 = '0;
  bram_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(3)) bus3 ();

  bram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en3),
    .wr_addr (wr_addr3),
    .wr_data (wr_data3),
    .bus     (bus3.slave),
    .idle    (idle3),
    .ptr     (ptr3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the two-requester instance. Inputs are driven just after the
  // rising edge and outputs are checked at the falling edge. resp_data is
  // checked only when a response is expected.
  task automatic cyc(input string tag, input logic we, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [1:0] v,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [1:0] er, input logic [1:0] erv,
                     input logic [DW-1:0] ed);
    @(posedge clk);
    #1;
    wr_en          = we;
    wr_addr        = wa;
    wr_data        = wd;
    bus2.req_valid = v;
    bus2.req_addr  = {a1, a0};
    @(negedge clk);
    chk({tag, ".ready"}, 64'(bus2.req_ready), 64'(er));
    chk({tag, ".resp_valid"}, 64'(bus2.resp_valid), 64'(erv));
    if (erv != 2'b00) chk({tag, ".resp_data"}, 64'(bus2.resp_data), 64'(ed));
  endtask

  initial begin
    bus2.req_valid = 2'b11;
    bus2.req_addr  = '0;
    bus3.req_valid = '0;
    bus3.req_addr  = '0;

    // reset state: a grant is suppressed even though both requesters are valid
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 64'(bus2.req_ready), 64'h0);
    chk("rst.resp_valid", 64'(bus2.resp_valid), 64'h0);
    chk("rst.idle", 64'(idle2), 64'h1);
    chk("rst.ptr", 64'(ptr2), 64'h0);
    chk("rst.idle3", 64'(idle3), 64'h1);
    bus2.req_valid = 2'b00;
    rst_n = 1'b1;

    // preload: addr0..3 = C0..C3, addr7 = 11
    cyc("pre0", 1'b1, 10'd0, 32'hC0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    cyc("pre1", 1'b1, 10'd1, 32'hC1, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    cyc("pre2", 1'b1, 10'd2, 32'hC2, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    cyc("pre3", 1'b1, 10'd3, 32'hC3, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    cyc("pre7", 1'b1, 10'd7, 32'h11, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);

    // single read of addr 5 after writing A5 there
    cyc("wr5", 1'b1, 10'd5, 32'hA5, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    cyc("rd5.t0", 1'b0, 10'd0, 32'h0, 2'b01, 10'd5, 10'd0, 2'b01, 2'b00, 32'h0);
    cyc("rd5.t1", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    chk("rd5.t1.idle", 64'(idle2), 64'h0);
    cyc("rd5.t2", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b01, 32'hA5);
    cyc("rd5.t3", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    chk("rd5.t3.idle", 64'(idle2), 64'h1);
    chk("rd5.ptr", 64'(ptr2), 64'h1);

    // requester 1 alone for three cycles; the pointer wraps to 0 after each grant
    cyc("solo.c0", 1'b0, 10'd0, 32'h0, 2'b10, 10'd0, 10'd2, 2'b10, 2'b00, 32'h0);
    cyc("solo.c1", 1'b0, 10'd0, 32'h0, 2'b10, 10'd0, 10'd2, 2'b10, 2'b00, 32'h0);
    chk("solo.c1.ptr", 64'(ptr2), 64'h0);
    cyc("solo.c2", 1'b0, 10'd0, 32'h0, 2'b10, 10'd0, 10'd2, 2'b10, 2'b10, 32'hC2);
    chk("solo.c2.ptr", 64'(ptr2), 64'h0);
    cyc("solo.c3", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b10, 32'hC2);
    cyc("solo.c4", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b10, 32'hC2);
    cyc("solo.c5", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);
    chk("solo.ptr", 64'(ptr2), 64'h0);

    // both valid for four cycles: grants and responses alternate 0,1,0,1
    cyc("rr.c0", 1'b0, 10'd0, 32'h0, 2'b11, 10'd0, 10'd1, 2'b01, 2'b00, 32'h0);
    cyc("rr.c1", 1'b0, 10'd0, 32'h0, 2'b11, 10'd0, 10'd1, 2'b10, 2'b00, 32'h0);
    cyc("rr.c2", 1'b0, 10'd0, 32'h0, 2'b11, 10'd0, 10'd1, 2'b01, 2'b01, 32'hC0);
    cyc("rr.c3", 1'b0, 10'd0, 32'h0, 2'b11, 10'd0, 10'd1, 2'b10, 2'b10, 32'hC1);
    cyc("rr.c4", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b01, 32'hC0);
    cyc("rr.c5", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b10, 32'hC1);
    cyc("rr.c6", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);

    // read during a same-address write returns the old data; the next read sees the new data
    cyc("col.c0", 1'b1, 10'd7, 32'h22, 2'b10, 10'd0, 10'd7, 2'b10, 2'b00, 32'h0);
    cyc("col.c1", 1'b0, 10'd0, 32'h0, 2'b10, 10'd0, 10'd7, 2'b10, 2'b00, 32'h0);
    cyc("col.c2", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b10, 32'h11);
    cyc("col.c3", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b10, 32'h22);
    cyc("col.c4", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);

    // reset while a read is in flight: the read is dropped and the pointer is cleared
    cyc("rip.t0", 1'b0, 10'd0, 32'h0, 2'b01, 10'd1, 10'd0, 2'b01, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    bus2.req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rip.t1.resp_valid", 64'(bus2.resp_valid), 64'h0);
    chk("rip.t1.idle", 64'(idle2), 64'h1);
    chk("rip.t1.ptr", 64'(ptr2), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rip.t2.resp_valid", 64'(bus2.resp_valid), 64'h0);
    chk("rip.t2.idle", 64'(idle2), 64'h1);
    chk("rip.t2.ptr", 64'(ptr2), 64'h0);
    cyc("rip.t3", 1'b0, 10'd0, 32'h0, 2'b00, 10'd0, 10'd0, 2'b00, 2'b00, 32'h0);

    // three requesters: move the pointer to 2, then all valid -> grant order 2,0,1
    @(posedge clk);
    #1;
    bus3.req_valid = 3'b010;
    @(negedge clk);
    chk("n3.c0.ready", 64'(bus3.req_ready), 64'h2);
    @(posedge clk);
    #1;
    bus3.req_valid = 3'b111;
    @(negedge clk);
    chk("n3.c1.ptr", 64'(ptr3), 64'h2);
    chk("n3.c1.ready", 64'(bus3.req_ready), 64'h4);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("n3.c2.ready", 64'(bus3.req_ready), 64'h1);
    chk("n3.c2.resp_valid", 64'(bus3.resp_valid), 64'h2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("n3.c3.ready", 64'(bus3.req_ready), 64'h2);
    chk("n3.c3.resp_valid", 64'(bus3.resp_valid), 64'h4);
    @(posedge clk);
    #1;
    bus3.req_valid = 3'b000;
    @(negedge clk);
    chk("n3.c4.resp_valid", 64'(bus3.resp_valid), 64'h1);
    chk("n3.c4.ptr", 64'(ptr3), 64'h2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("n3.c5.resp_valid", 64'(bus3.resp_valid), 64'h2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("n3.c6.idle", 64'(idle3), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_rd_arbiter.md
BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, bits per RAM word.
REQ-002 Parameter: ADDR_WIDTH, default 10, address bits; RAM depth 2**ADDR_WIDTH.
REQ-003 Parameter: NUM_REQ, default 2, number of read requesters; legal range 2..8.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  RAM write enable, not arbitrated.
REQ-008 wr_addr  in  ADDR_WIDTH  write address.
REQ-009 wr_data  in  DATA_WIDTH  write data.
REQ-010 req_valid  in  NUM_REQ  per-requester read request.
REQ-011 req_addr  in  NUM_REQ x ADDR_WIDTH  per-requester read address.
REQ-012 req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
REQ-013 resp_valid  out  NUM_REQ  per-requester read-data strobe; one-hot or zero.
REQ-014 resp_data  out  DATA_WIDTH  read data, shared by all requesters.
REQ-015 idle  out  1  high when no read is in flight.

Function
REQ-016 A read transfers in any cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 req_ready is combinational from req_valid and the priority pointer; at most one bit is high per cycle.
REQ-018 req_ready[i] is never high while req_valid[i] is low.
REQ-019 Arbitration is round-robin: the first valid requester at or after the pointer, in ascending index with wrap, is granted.
REQ-020 After a grant to i, the pointer becomes (i+1) mod NUM_REQ; with no grant, the pointer holds.
REQ-021 The granted req_addr drives the RAM read address in the grant cycle; with no grant, the read address is 0 and no tag is issued.
REQ-022 Latency is fixed: a grant in cycle T gives resp_valid[i]=1 and valid resp_data in cycle T+2, for exactly one cycle.
REQ-023 A 2-stage tag pipeline carries (valid, requester id) alongside the RAM pipeline.
REQ-024 Throughput is one read per cycle; back-to-back grants give back-to-back responses in grant order.
REQ-025 Responses have no backpressure; requesters shall accept resp_valid unconditionally.
REQ-026 Read and write to the same address in the same cycle returns the old data.
REQ-027 Writes take effect at the clock edge regardless of read arbitration.
REQ-028 idle=1 when both tag stages are invalid.
REQ-029 resp_data is don't-care when resp_valid is all zero.

Reset
REQ-030 rst_n low clears the pointer to 0, both tag stages to invalid, resp_valid to 0 and idle to 1, asynchronously.
REQ-031 Reads in flight at reset are discarded; no resp_valid for them after rst_n deasserts.
REQ-032 req_ready is 0 while rst_n is low.
REQ-033 RAM contents and resp_data are not reset.

Structure
REQ-034 Package bram_arb_pkg holds READ_LATENCY=2 and the requester-id width function clog2(NUM_REQ).
REQ-035 Instantiate the existing 2-cycle registered-output block RAM as the single sub-module (bram), connected to this block's write port and the arbitrated read address.

Verification
REQ-036 Write 0xA5 to addr 5, then requester 0 reads addr 5 at T -> resp_valid=01 at T+2, resp_data=0xA5, idle=1 at T+3.
REQ-037 Both requesters hold valid for 4 cycles, pointer starting at 0 -> grants 0,1,0,1; responses 0,1,0,1 at T+2..T+5.
REQ-038 Addr 7 holds 0x11; write 0x22 to addr 7 while requester 1 reads addr 7 -> resp_data=0x11; a read one cycle later -> 0x22.
REQ-039 Only requester 1 valid for 3 cycles -> granted every cycle, pointer wraps to 0 each time, three consecutive resp_valid=10.
REQ-040 Grant at T, rst_n low at T+1 -> no resp_valid at T+2; after release, idle=1 and pointer=0.
REQ-041 NUM_REQ=3, all valid, pointer at 2 -> grant order 2,0,1.
